// File: rtl/processor_pkg.sv
// Shared processor definitions: FSM state encoding, opcodes and ALU selects.
// The Datapath ALU imports the same ALU select constants.
package processor_pkg;

    localparam int PC_W = 7;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOADA  = 4'd3,
        S_LOADB  = 4'd4,
        S_STORE  = 4'd5,
        S_ADD    = 4'd6,
        S_SUB    = 4'd7,
        S_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OP_NOOP  = 4'b0000;
    localparam logic [3:0] OP_STORE = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_HALT  = 4'b0101;

    localparam logic [2:0] ALU_PASS = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_SUB  = 3'd2;

endpackage

// File: rtl/pc_ir_reg.sv
// Program counter and instruction register, loaded together on one strobe.
// The PC wraps naturally at its width (127 -> 0 for a 7-bit PC).
module pc_ir_reg #(
    parameter int PC_W = 7
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_ld_en,
    input  logic [15:0]     i_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [15:0]     o_ir
);

    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pc <= '0;
            r_ir <= '0;
        end else if (i_ld_en) begin
            r_pc <= r_pc + 1'b1;
            r_ir <= i_instr;
        end
    end

    assign o_pc = r_pc;
    assign o_ir = r_ir;

endmodule

// File: rtl/control_unit.sv
// Sequencing controller: fetches instructions, decodes them with a Moore FSM
// and drives every datapath control input from the current state and IR.
//
// state   | meaning
// --------+-----------------------------------------------
// Init    | post-reset idle cycle
// Fetch   | IR <= ROM[PC], PC <= PC + 1
// Decode  | dispatch on opcode
// LoadA   | data memory read settles, no write yet
// LoadB   | RF[ra] <= D[d]
// Store   | D[d] <= RF[ra]
// Add     | RF[rc] <= RF[ra] + RF[rb]
// Sub     | RF[rc] <= RF[ra] - RF[rb]
// Halt    | frozen until reset
module control_unit
    import processor_pkg::*;
#(
    parameter int PC_W = 7
) (
    input  logic            i_Clk,
    input  logic            i_Reset,
    input  logic [15:0]     i_Instr_in,
    output logic [PC_W-1:0] o_PC_Addr,
    output logic [7:0]      o_D_Addr,
    output logic            o_D_Wr,
    output logic            o_RF_s,
    output logic [3:0]      o_RF_W_Addr,
    output logic            o_RF_W_en,
    output logic [3:0]      o_RF_Ra_Addr,
    output logic [3:0]      o_RF_Rb_Addr,
    output logic [2:0]      o_ALU_s0,
    output logic [3:0]      o_State,
    output logic            o_Halted
);

    state_t          r_state;
    state_t          w_next;
    logic            w_ld_en;
    logic [15:0]     w_ir;
    logic [PC_W-1:0] w_pc;
    logic [3:0]      w_op;
    logic [3:0]      w_ra;
    logic [3:0]      w_rb;
    logic [3:0]      w_rc;
    logic [7:0]      w_d;

    pc_ir_reg #(.PC_W(PC_W)) u_pc_ir (
        .i_clk   (i_Clk),
        .i_rst   (i_Reset),
        .i_ld_en (w_ld_en),
        .i_instr (i_Instr_in),
        .o_pc    (w_pc),
        .o_ir    (w_ir)
    );

    assign w_op = w_ir[15:12];
    assign w_ra = w_ir[11:8];
    assign w_rb = w_ir[7:4];
    assign w_rc = w_ir[3:0];
    assign w_d  = w_ir[7:0];

    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) r_state <= S_INIT;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_LOAD:  w_next = S_LOADA;
                    OP_STORE: w_next = S_STORE;
                    OP_ADD:   w_next = S_ADD;
                    OP_SUB:   w_next = S_SUB;
                    OP_HALT:  w_next = S_HALT;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_LOADA:  w_next = S_LOADB;
            S_LOADB:  w_next = S_FETCH;
            S_STORE:  w_next = S_FETCH;
            S_ADD:    w_next = S_FETCH;
            S_SUB:    w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_INIT;
        endcase
    end

    // Moore outputs: every state starts from the all-idle defaults.
    always_comb begin
        w_ld_en      = 1'b0;
        o_D_Addr     = '0;
        o_D_Wr       = 1'b0;
        o_RF_s       = 1'b0;
        o_RF_W_Addr  = '0;
        o_RF_W_en    = 1'b0;
        o_RF_Ra_Addr = '0;
        o_RF_Rb_Addr = '0;
        o_ALU_s0     = ALU_PASS;
        o_Halted     = 1'b0;
        case (r_state)
            S_FETCH: w_ld_en = 1'b1;
            S_LOADA, S_LOADB: begin
                o_D_Addr    = w_d;
                o_RF_s      = 1'b1;
                o_RF_W_Addr = w_ra;
                o_RF_W_en   = (r_state == S_LOADB);
            end
            S_STORE: begin
                o_D_Addr     = w_d;
                o_RF_Ra_Addr = w_ra;
                o_D_Wr       = 1'b1;
            end
            S_ADD, S_SUB: begin
                o_RF_Ra_Addr = w_ra;
                o_RF_Rb_Addr = w_rb;
                o_RF_W_Addr  = w_rc;
                o_RF_W_en    = 1'b1;
                o_ALU_s0     = (r_state == S_ADD) ? ALU_ADD : ALU_SUB;
            end
            S_HALT: o_Halted = 1'b1;
            default: ;
        endcase
    end

    assign o_PC_Addr = w_pc;
    assign o_State   = r_state;

endmodule
